fp_sub_iter: RTL and testbench

- Multi-cycle IEEE-754 double-precision subtractor: result = A − B.
- Complements the combinational adder in the FSQRT datapath. Uses bit-serial alignment and normalisation instead of barrel shifters, trading latency for area.
- Valid/ready handshakes on both sides, so the Newton-iteration sequencer can issue residual subtractions back-to-back.

---
 rtl/fp64_pkg.sv | 38 +++
 rtl/fp_sub_iter_if.sv | 21 ++
 rtl/fp_round_rne.sv | 31 +++
 rtl/fp_sub_iter.sv | 168 ++++++++++++++++
 tb/tb_fp_sub_iter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fp64_pkg.sv
// rtl/fp64_pkg.sv - binary64 field widths, constants, FSM states and unpack helper
package fp64_pkg;

    localparam int EXP_W = 11;
    localparam int MAN_W = 52;
    localparam int EXT_W = 56;

    localparam logic [EXP_W-1:0] EXP_MAX   = 11'd2047;
    localparam logic [63:0]      CANON_NAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0]      POS_INF   = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0]      NEG_INF   = 64'hFFF0_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_ALIGN,
        ST_ARITH,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } fp_sub_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [EXT_W-1:0] man_ext;
    } fp_unpacked_t;

    // Hidden one restored, three guard/round/sticky bits appended below the LSB.
    function automatic fp_unpacked_t fp_unpack(input logic [62:0] mag, input logic sign);
        fp_unpacked_t u;
        u.sign    = sign;
        u.exp     = mag[62:52];
        u.man_ext = {1'b1, mag[51:0], 3'b000};
        return u;
    endfunction

endpackage

// File: rtl/fp_sub_iter_if.sv
// rtl/fp_sub_iter_if.sv - operand/result handshake bundle for the iterative subtractor
interface fp_sub_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;
    logic        busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even on a normalised 56-bit mantissa
module fp_round_rne
    import fp64_pkg::*;
(
    input  logic [EXT_W-1:0] man,
    input  logic [EXP_W:0]   exp,
    output logic [MAN_W-1:0] frac,
    output logic [EXP_W-1:0] exp_out,
    output logic             overflow
);

    logic             inc;
    logic [MAN_W+1:0] rounded;
    logic [EXP_W:0]   exp_adj;

    // man[3] is the result LSB, man[2:0] are guard, round and sticky.
    always_comb begin
        inc     = man[2] & (man[1] | man[0] | man[3]);
        rounded = {1'b0, man[EXT_W-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        if (rounded[MAN_W+1]) begin
            frac    = rounded[MAN_W:1];
            exp_adj = exp + {{EXP_W{1'b0}}, 1'b1};
        end else begin
            frac    = rounded[MAN_W-1:0];
            exp_adj = exp;
        end
        overflow = exp_adj >= {1'b0, EXP_MAX};
        exp_out  = exp_adj[EXP_W-1:0];
    end

endmodule

// File: rtl/fp_sub_iter.sv
// rtl/fp_sub_iter.sv - multi-cycle binary64 subtractor A - B with bit-serial align/normalise
module fp_sub_iter
    import fp64_pkg::*;
#(
    parameter int          MAX_ALIGN = 56,
    parameter logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_sub_iter_if.slave io
);

    localparam logic [EXP_W-1:0] MAX_ALIGN_W = EXP_W'(MAX_ALIGN);

    fp_sub_state_t    state;
    logic [63:0]      a_r, b_r;
    logic [EXT_W-1:0] big_man, small_man;
    logic             eff_sub;
    logic             res_sign;
    logic [EXP_W:0]   res_exp;
    logic [EXT_W:0]   res_man;
    logic [EXP_W-1:0] align_cnt;

    fp_unpacked_t     u_a, u_b, u_big, u_small;
    logic             a_ge;
    logic [EXP_W-1:0] exp_diff;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             sa, sb;
    logic             special_hit;
    logic [63:0]      special_val;
    logic [EXT_W:0]   arith_res;

    logic [MAN_W-1:0] rnd_frac;
    logic [EXP_W-1:0] rnd_exp;
    logic             rnd_ovf;

    assign sa     = a_r[63];
    assign sb     = ~b_r[63];
    assign a_nan  = (a_r[62:52] == EXP_MAX) && (a_r[51:0] != '0);
    assign b_nan  = (b_r[62:52] == EXP_MAX) && (b_r[51:0] != '0);
    assign a_inf  = (a_r[62:52] == EXP_MAX) && (a_r[51:0] == '0);
    assign b_inf  = (b_r[62:52] == EXP_MAX) && (b_r[51:0] == '0);
    assign a_zero = (a_r[62:52] == '0);
    assign b_zero = (b_r[62:52] == '0);

    always_comb begin
        u_a      = fp_unpack(a_r[62:0], sa);
        u_b      = fp_unpack(b_r[62:0], sb);
        a_ge     = a_r[62:0] >= b_r[62:0];
        u_big    = a_ge ? u_a : u_b;
        u_small  = a_ge ? u_b : u_a;
        exp_diff = u_big.exp - u_small.exp;

        special_hit = 1'b1;
        special_val = '0;
        if (a_nan || b_nan)     special_val = CANON_NAN;
        else if (a_inf && b_inf) special_val = (sa == sb) ? {sa, a_r[62:0]} : CANON_NAN;
        else if (a_inf)          special_val = {sa, a_r[62:0]};
        else if (b_inf)          special_val = {sb, b_r[62:0]};
        else if (a_zero && b_zero) special_val = {sa & sb, 63'd0};
        else if (a_zero)         special_val = {sb, b_r[62:0]};
        else if (b_zero)         special_val = {sa, a_r[62:0]};
        else                     special_hit = 1'b0;

        // big_man >= small_man after alignment, so the difference never wraps.
        if (eff_sub) arith_res = {1'b0, big_man} - {1'b0, small_man};
        else         arith_res = {1'b0, big_man} + {1'b0, small_man};
    end

    fp_round_rne u_round (
        .man      (res_man[EXT_W-1:0]),
        .exp      (res_exp),
        .frac     (rnd_frac),
        .exp_out  (rnd_exp),
        .overflow (rnd_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            io.in_ready  <= 1'b1;
            io.out_valid <= 1'b0;
            io.out       <= '0;
            io.busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (io.in_valid) begin
                        a_r         <= io.A;
                        b_r         <= io.B;
                        io.in_ready <= 1'b0;
                        io.busy     <= 1'b1;
                        state       <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    if (special_hit) begin
                        io.out       <= special_val;
                        io.out_valid <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        big_man   <= u_big.man_ext;
                        small_man <= u_small.man_ext;
                        eff_sub   <= u_big.sign != u_small.sign;
                        res_sign  <= u_big.sign;
                        res_exp   <= {1'b0, u_big.exp};
                        align_cnt <= exp_diff;
                        state     <= (exp_diff == '0) ? ST_ARITH : ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (align_cnt >= MAX_ALIGN_W) begin
                        small_man <= {{(EXT_W-1){1'b0}}, 1'b1};
                        state     <= ST_ARITH;
                    end else begin
                        small_man <= {1'b0, small_man[EXT_W-1:2], small_man[1] | small_man[0]};
                        align_cnt <= align_cnt - 11'd1;
                        if (align_cnt == 11'd1) state <= ST_ARITH;
                    end
                end
                ST_ARITH: begin
                    if (arith_res == '0) begin
                        io.out       <= '0;
                        io.out_valid <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        res_man <= arith_res;
                        state   <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (res_man[EXT_W]) begin
                        res_man <= {1'b0, res_man[EXT_W:2], res_man[1] | res_man[0]};
                        res_exp <= res_exp + 12'd1;
                        state   <= ST_ROUND;
                    end else if (res_man[EXT_W-1]) begin
                        state <= ST_ROUND;
                    end else if (res_exp == 12'd1) begin
                        io.out       <= {res_sign, 63'd0};
                        io.out_valid <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        // Look one bit ahead so a k-bit shift costs exactly k cycles.
                        res_man <= {res_man[EXT_W-1:0], 1'b0};
                        res_exp <= res_exp - 12'd1;
                        if (res_man[EXT_W-2]) state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    io.out       <= rnd_ovf ? {res_sign, EXP_MAX, {MAN_W{1'b0}}}
                                            : {res_sign, rnd_exp, rnd_frac};
                    io.out_valid <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_DONE: begin
                    if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        io.in_ready  <= 1'b1;
                        io.busy      <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sub_iter.sv
// tb/tb_fp_sub_iter.sv - vector table plus scoreboard bench for fp_sub_iter
module tb_fp_sub_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_sub_iter_if io();

    fp_sub_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_out;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] out;
        int          lat;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic add_vec(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] e, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.exp_out = e; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic push_sb(input logic [63:0] e, input int lat);
        sb_t s;
        s.out = e; s.lat = lat;
        sb_q.push_back(s);
    endtask

    // Drives one operand pair and returns #1 after the accept edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] e, input int lat);
        int k = 0;
        while (!io.in_ready && k < 300) begin
            @(posedge clk); #1; k++;
        end
        check64("in_ready_before_issue", {63'd0, io.in_ready}, 64'd1);
        io.A = a;
        io.B = b;
        io.in_valid = 1'b1;
        push_sb(e, lat);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!io.out_valid && k < 300) begin
            @(posedge clk); #1; k++;
        end
    endtask

    // Latency counts the accept cycle itself plus the edges until out_valid.
    task automatic collect(input string name);
        sb_t exp_r;
        int  k;
        wait_valid(k);
        check64({name, "_valid"}, {63'd0, io.out_valid}, 64'd1);
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected entry", name);
        end else begin
            exp_r = sb_q.pop_front();
            check64(name, io.out, exp_r.out);
            if (exp_r.lat != 0) check_int({name, "_lat"}, k + 1, exp_r.lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int          k;
        logic [63:0] held;
        sb_t         exp_r;

        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        io.A         = '0;
        io.B         = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check64("rst_in_ready",  {63'd0, io.in_ready},  64'd1);
        check64("rst_out_valid", {63'd0, io.out_valid}, 64'd0);
        check64("rst_out",       io.out,                64'd0);
        check64("rst_busy",      {63'd0, io.busy},      64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        add_vec(64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 6);
        add_vec(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 0);
        add_vec(64'h3FF0000000000000, 64'hBFF0000000000000, 64'h4000000000000000, 5);
        add_vec(64'h3FF0000000000000, 64'h3C30000000000000, 64'h3FF0000000000000, 6);
        add_vec(64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 2);
        add_vec(64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, 2);
        add_vec(64'h3FF0000000000000, 64'hFFF0000000000000, 64'h7FF0000000000000, 2);
        add_vec(64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 2);
        add_vec(64'h0000000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000, 2);
        add_vec(64'h8000000000000000, 64'h0000000000000000, 64'h8000000000000000, 2);
        add_vec(64'h0000000000000000, 64'h0000000000000000, 64'h0000000000000000, 2);
        add_vec(64'h8000000000000000, 64'h8000000000000000, 64'h0000000000000000, 2);
        add_vec(64'h3FF0000000000000, 64'h4008000000000000, 64'hC000000000000000, 6);
        add_vec(64'h3FF8000000000000, 64'h3FF0000000000000, 64'h3FE0000000000000, 5);
        add_vec(64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 64'h7FF0000000000000, 5);
        add_vec(64'h3FF0000000000000, 64'hBCA0000000000000, 64'h3FF0000000000000, 58);
        add_vec(64'h3FF0000000000001, 64'hBCA0000000000000, 64'h3FF0000000000002, 58);
        add_vec(64'h3FF0000000000000, 64'h0000000000000001, 64'h3FF0000000000000, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].lat);
            collect($sformatf("vec%0d", i));
        end

        // Output stall with a competing in_valid held during busy.
        io.out_ready = 1'b0;
        issue(64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 6);
        wait_valid(k);
        check_int("stall_lat", k + 1, 6);
        exp_r = sb_q.pop_front();
        check64("stall_first", io.out, exp_r.out);
        held = exp_r.out;
        io.A = 64'h7FF8000000000000;
        io.B = 64'h3FF0000000000000;
        io.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check64("stall_out",      io.out,                held);
            check64("stall_in_ready", {63'd0, io.in_ready},  64'd0);
            check64("stall_valid",    {63'd0, io.out_valid}, 64'd1);
        end
        io.A = 64'h3FF0000000000000;
        io.B = 64'hBFF0000000000000;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        check64("release_in_ready",  {63'd0, io.in_ready},  64'd1);
        check64("release_busy",      {63'd0, io.busy},      64'd0);
        check64("release_out_valid", {63'd0, io.out_valid}, 64'd0);
        push_sb(64'h4000000000000000, 5);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        collect("reissue");

        // Reset abandons a long alignment.
        io.A = 64'h3FF0000000000000;
        io.B = 64'hBCA0000000000000;
        io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check64("align_busy", {63'd0, io.busy}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check64("midrst_out_valid", {63'd0, io.out_valid}, 64'd0);
        check64("midrst_in_ready",  {63'd0, io.in_ready},  64'd1);
        check64("midrst_out",       io.out,                64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 6);
        collect("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
